// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer
//
// Commutation scheduler shared by the three line generators. It runs a
// period counter (m3cnt) inside PWM sub-steps (m3LpwmSplitStep) inside
// commutation steps (lgStep). It also produces the end-of-period strobes
// that all phases consume, so the phases advance in lock-step.
//
// Ports:
//   clk, rst               - system clock; asynchronous active-high reset
//   m3start, m3stop        - single-cycle run / stop requests (stop wins)
//   m3dir                  - 0: step increments, 1: step decrements
//   m3r_stepCNT_speedSET   - sub-step length minus 1 (clamped to LEN_MIN)
//   m3r_stepSplitMax       - PWM sub-steps per step minus 1
//   lgStep                 - step index, 4'hF when all phases are off
//   m3LpwmSplitStep        - sub-step index inside the current step
//   m3cnt                  - clock count inside the current sub-step
//   m3cntLast1/m3cntLast2  - m3cnt == length / length-1
//   m3stepPulse            - first cycle of every new step
//   m3busy                 - running or finishing the current step
//
// All outputs are registered.

module motoro3_step_sequencer #(
    parameter int CNT_W    = 25,
    parameter int STEP_MAX = 5,
    parameter int LEN_MIN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m3start,
    input  logic             m3stop,
    input  logic             m3dir,
    input  logic [CNT_W-1:0] m3r_stepCNT_speedSET,
    input  logic [1:0]       m3r_stepSplitMax,
    output logic [3:0]       lgStep,
    output logic [1:0]       m3LpwmSplitStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntLast1,
    output logic             m3cntLast2,
    output logic             m3stepPulse,
    output logic             m3busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    localparam logic [3:0]       STEP_OFF  = 4'hF;
    localparam logic [3:0]       STEP_LAST = 4'(STEP_MAX);
    localparam logic [CNT_W-1:0] LEN_FLOOR = CNT_W'(LEN_MIN);

    logic [1:0]       state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [1:0]       split_q, split_d;
    logic [1:0]       split_max_q, split_max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             dir_q, dir_d;
    logic             last1_q, last1_d;
    logic             last2_q, last2_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] len_clamped;
    logic             sub_end;
    logic             step_end;
    logic             stop_pending;
    logic [3:0]       step_next;

    always_comb begin
        len_clamped = (m3r_stepCNT_speedSET < LEN_FLOOR) ? LEN_FLOOR : m3r_stepCNT_speedSET;
        sub_end     = (cnt_q == len_q);
        step_end    = sub_end && (split_q == split_max_q);
        // A stop request is honoured if it arrives now or was seen earlier.
        stop_pending = (state_q == ST_STOPPING) || m3stop;

        // The direction sampled at the boundary steers the step being entered.
        if (m3dir) begin
            step_next = (step_q == 4'd0) ? STEP_LAST : step_q - 4'd1;
        end else begin
            step_next = (step_q == STEP_LAST) ? 4'd0 : step_q + 4'd1;
        end

        state_d     = state_q;
        step_d      = step_q;
        split_d     = split_q;
        split_max_d = split_max_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        dir_d       = dir_q;
        pulse_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m3start && !m3stop) begin
                    state_d     = ST_RUN;
                    step_d      = 4'd0;
                    split_d     = 2'd0;
                    cnt_d       = '0;
                    len_d       = len_clamped;
                    split_max_d = m3r_stepSplitMax;
                    dir_d       = m3dir;
                    pulse_d     = 1'b1;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (step_end && stop_pending) begin
                    state_d = ST_IDLE;
                    step_d  = STEP_OFF;
                    split_d = 2'd0;
                    cnt_d   = '0;
                end else begin
                    state_d = stop_pending ? ST_STOPPING : ST_RUN;
                    if (sub_end) begin
                        cnt_d = '0;
                        len_d = len_clamped;
                        if (split_q == split_max_q) begin
                            split_d     = 2'd0;
                            step_d      = step_next;
                            split_max_d = m3r_stepSplitMax;
                            dir_d       = m3dir;
                            pulse_d     = 1'b1;
                        end else begin
                            split_d = split_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = STEP_OFF;
                split_d = 2'd0;
                cnt_d   = '0;
            end
        endcase

        // Strobes are decoded from the next count so they line up with m3cnt.
        busy_d  = (state_d != ST_IDLE);
        last1_d = busy_d && (cnt_d == len_d);
        last2_d = busy_d && (cnt_d == (len_d - CNT_W'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_OFF;
            split_q     <= 2'd0;
            split_max_q <= 2'd0;
            cnt_q       <= '0;
            len_q       <= LEN_FLOOR;
            dir_q       <= 1'b0;
            last1_q     <= 1'b0;
            last2_q     <= 1'b0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            split_q     <= split_d;
            split_max_q <= split_max_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            dir_q       <= dir_d;
            last1_q     <= last1_d;
            last2_q     <= last2_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign lgStep          = step_q;
    assign m3LpwmSplitStep = split_q;
    assign m3cnt           = cnt_q;
    assign m3cntLast1      = last1_q;
    assign m3cntLast2      = last2_q;
    assign m3stepPulse     = pulse_q;
    assign m3busy          = busy_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Testbench for motoro3_step_sequencer: directed scenarios plus a randomized
// run, all compared against a behavioural model of the scheduling rules.

module tb_motoro3_step_sequencer;

    localparam int CNT_W   = 25;
    localparam int LEN_MIN = 3;
    localparam int NSTEPS  = 6;
    localparam int VW      = 4 + 2 + CNT_W + 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             dir = 1'b0;
    logic [CNT_W-1:0] speed = '0;
    logic [1:0]       smax_in = 2'd0;

    logic [3:0]       lgStep;
    logic [1:0]       m3LpwmSplitStep;
    logic [CNT_W-1:0] m3cnt;
    logic             m3cntLast1, m3cntLast2, m3stepPulse, m3busy;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] idle_vec = {4'hF, {(VW-4){1'b0}}};

    motoro3_step_sequencer #(.CNT_W(CNT_W), .STEP_MAX(5), .LEN_MIN(LEN_MIN)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .m3start              (start),
        .m3stop               (stop),
        .m3dir                (dir),
        .m3r_stepCNT_speedSET (speed),
        .m3r_stepSplitMax     (smax_in),
        .lgStep               (lgStep),
        .m3LpwmSplitStep      (m3LpwmSplitStep),
        .m3cnt                (m3cnt),
        .m3cntLast1           (m3cntLast1),
        .m3cntLast2           (m3cntLast2),
        .m3stepPulse          (m3stepPulse),
        .m3busy               (m3busy)
    );

    always #50 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_run, m_stopping, m_pulse;
    int m_step, m_sub, m_cnt, m_len, m_smax;

    function automatic int clamp_len(input int v);
        return (v < LEN_MIN) ? LEN_MIN : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_stopping = 0; m_pulse = 0;
        m_step = 0; m_sub = 0; m_cnt = 0; m_len = LEN_MIN; m_smax = 0;
    endtask

    task automatic model_step();
        bit sub_done, step_done;
        m_pulse = 0;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_stopping = 0;
                m_step = 0; m_sub = 0; m_cnt = 0;
                m_len = clamp_len(int'(speed)); m_smax = int'(smax_in);
                m_pulse = 1;
            end
        end else begin
            sub_done  = (m_cnt == m_len);
            step_done = sub_done && (m_sub == m_smax);
            if (stop) m_stopping = 1;
            if (step_done && m_stopping) begin
                m_run = 0; m_stopping = 0; m_step = 0; m_sub = 0; m_cnt = 0;
            end else if (sub_done) begin
                m_cnt = 0;
                m_len = clamp_len(int'(speed));
                if (m_sub == m_smax) begin
                    m_sub  = 0;
                    m_smax = int'(smax_in);
                    m_step = dir ? (m_step + NSTEPS - 1) % NSTEPS : (m_step + 1) % NSTEPS;
                    m_pulse = 1;
                end else begin
                    m_sub++;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [3:0] s;
        s = m_run ? 4'(m_step) : 4'hF;
        return {s, 2'(m_sub), CNT_W'(m_cnt),
                m_run && (m_cnt == m_len), m_run && (m_cnt == m_len - 1),
                m_pulse, m_run};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {lgStep, m3LpwmSplitStep, m3cnt, m3cntLast1, m3cntLast2, m3stepPulse, m3busy};
    endfunction

    // One clock: model follows the same sampled inputs, pulses are dropped after.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== idle_vec) begin
            errors++; $display("FAIL reset_vals got=%h exp=%h", dut_vec(), idle_vec);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_vec() !== idle_vec) begin
                errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, dut_vec(), idle_vec);
            end
        end
    endtask

    task automatic test_forward();
        int seq[$];
        int pcyc[$];
        int exp_seq[7] = '{0, 1, 2, 3, 4, 5, 0};
        do_reset();
        speed = 25'd9; smax_in = 2'd1; dir = 1'b0; start = 1'b1;
        for (int i = 0; i <= 120; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL fwd_vec cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (m3stepPulse) begin seq.push_back(int'(lgStep)); pcyc.push_back(i); end
            if (m3cntLast1) begin
                checks++;
                if (m3cnt !== 25'd9) begin errors++; $display("FAIL fwd_last1 got=%0d exp=9", m3cnt); end
            end
            if (m3cntLast2) begin
                checks++;
                if (m3cnt !== 25'd8) begin errors++; $display("FAIL fwd_last2 got=%0d exp=8", m3cnt); end
            end
        end
        checks++;
        if (seq.size() != 7) begin
            errors++; $display("FAIL fwd_npulse got=%0d exp=7", seq.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (seq[k] != exp_seq[k]) begin
                    errors++; $display("FAIL fwd_seq k=%0d got=%0d exp=%0d", k, seq[k], exp_seq[k]);
                end
                if (k > 0 && (pcyc[k] - pcyc[k-1]) != 20) begin
                    errors++; $display("FAIL fwd_period k=%0d got=%0d exp=20", k, pcyc[k] - pcyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_reverse();
        int seq[$];
        int exp_seq[9] = '{0, 5, 4, 3, 2, 1, 0, 1, 2};
        do_reset();
        speed = 25'd9; smax_in = 2'd1; dir = 1'b1; start = 1'b1;
        for (int i = 0; i <= 160; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL rev_vec cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (m3stepPulse) seq.push_back(int'(lgStep));
            // mid-step toggle: the step still shown must not change early
            if (i == 130) dir = 1'b0;
            if (i == 139) begin
                checks++;
                if (lgStep !== 4'd0) begin errors++; $display("FAIL rev_toggle_early got=%0d exp=0", lgStep); end
            end
        end
        checks++;
        if (seq.size() != 9) begin
            errors++; $display("FAIL rev_npulse got=%0d exp=9", seq.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (seq[k] != exp_seq[k]) begin
                    errors++; $display("FAIL rev_seq k=%0d got=%0d exp=%0d", k, seq[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_clamp();
        int pcyc[$];
        do_reset();
        speed = 25'd1; smax_in = 2'd0; dir = 1'b0; start = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL clamp_vec cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (m3stepPulse) pcyc.push_back(i);
            if (m3cntLast1 && m3cnt !== 25'd3) begin
                errors++; $display("FAIL clamp_last1 got=%0d exp=3", m3cnt);
            end
            if (m3cntLast2 && m3cnt !== 25'd2) begin
                errors++; $display("FAIL clamp_last2 got=%0d exp=2", m3cnt);
            end
        end
        checks++;
        if (pcyc.size() != 11) begin
            errors++; $display("FAIL clamp_npulse got=%0d exp=11", pcyc.size());
        end else begin
            for (int k = 1; k < 11; k++) begin
                checks++;
                if (pcyc[k] - pcyc[k-1] != 4) begin
                    errors++; $display("FAIL clamp_period k=%0d got=%0d exp=4", k, pcyc[k] - pcyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_stop();
        int n;
        do_reset();
        speed = 25'd9; smax_in = 2'd1; dir = 1'b0; start = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if (m3cnt !== 25'd4 || m3LpwmSplitStep !== 2'd0) begin
            errors++; $display("FAIL stop_setup got=%0d/%0d exp=4/0", m3cnt, m3LpwmSplitStep);
        end
        stop = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL stop_vec n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
            end
            if (n == 15) begin
                checks++;
                if (!(m3cntLast1 === 1'b1 && m3busy === 1'b1)) begin
                    errors++; $display("FAIL stop_final_last1 got=%b%b exp=11", m3cntLast1, m3busy);
                end
            end
        end while (m3busy && n < 100);
        checks++;
        if (n != 16 || lgStep !== 4'hF) begin
            errors++; $display("FAIL stop_latency got=%0d step=%h exp=16 step=f", n, lgStep);
        end
        // stop in the very last cycle of a step goes straight to idle
        start = 1'b1;
        tick();
        repeat (19) tick();
        checks++;
        if (!(m3cntLast1 === 1'b1 && m3LpwmSplitStep === 2'd1)) begin
            errors++; $display("FAIL stop_last_setup got=%b/%0d exp=1/1", m3cntLast1, m3LpwmSplitStep);
        end
        stop = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== idle_vec || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL stop_last_direct got=%h exp=%h", dut_vec(), idle_vec);
        end
    endtask

    task automatic test_requests();
        do_reset();
        speed = 25'd5; smax_in = 2'd0; dir = 1'b0;
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut_vec() !== idle_vec) begin
                errors++; $display("FAIL startstop_idle cyc=%0d got=%h exp=%h", i, dut_vec(), idle_vec);
            end
        end
        stop = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== idle_vec) begin
            errors++; $display("FAIL stop_in_idle got=%h exp=%h", dut_vec(), idle_vec);
        end
        start = 1'b1;
        tick();
        repeat (3) tick();
        start = 1'b1;
        tick();
        checks++;
        if (m3cnt !== 25'd4 || m3stepPulse !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL start_in_run got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reconfig();
        int ends[$];
        do_reset();
        speed = 25'd9; smax_in = 2'd0; dir = 1'b0; start = 1'b1;
        tick();
        repeat (4) tick();
        speed = 25'd19;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL reconf_vec cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (m3cntLast1) ends.push_back(int'(m3cnt));
        end
        checks++;
        if (ends.size() < 2 || ends[0] != 9 || ends[1] != 19) begin
            errors++; $display("FAIL reconf_ends got=%0d entries first=%0d exp=9,19",
                               ends.size(), (ends.size() > 0) ? ends[0] : -1);
        end
    endtask

    task automatic test_reset_run();
        int n;
        do_reset();
        speed = 25'd3; smax_in = 2'd0; dir = 1'b0; start = 1'b1;
        n = 0;
        do begin tick(); n++; end while (lgStep !== 4'd3 && n < 50);
        checks++;
        if (lgStep !== 4'd3) begin errors++; $display("FAIL rstrun_reach got=%h exp=3", lgStep); end
        #20;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== idle_vec) begin
            errors++; $display("FAIL rstrun_async got=%h exp=%h", dut_vec(), idle_vec);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_vec() !== idle_vec) begin
                errors++; $display("FAIL rstrun_idle cyc=%0d got=%h exp=%h", i, dut_vec(), idle_vec);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        speed = 25'd4; smax_in = 2'd1; dir = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom % 16 == 0) speed = CNT_W'($urandom_range(0, 12));
            if ($urandom % 32 == 0) smax_in = 2'($urandom);
            if ($urandom % 16 == 0) dir = 1'($urandom);
            start = ($urandom % 8 == 0);
            stop  = ($urandom % 24 == 0);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL rand_vec cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward();
        test_reverse();
        test_clamp();
        test_stop();
        test_requests();
        test_reconfig();
        test_reset_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
